// File: rtl/feature_writer_pkg.sv
// Shared types and width helpers for the feature writer.
// FSM encoding, slot/word width functions used by feature_writer and fw_pack_reg.
package feature_writer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } fw_state_e;

    localparam int PACK_DEF       = 4;
    localparam int SLOT_WIDTH_DEF = $clog2(PACK_DEF);

    function automatic int slot_width(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

    function automatic int word_width(input int elem_width, input int pack);
        return elem_width * pack;
    endfunction

endpackage

// File: rtl/fw_pack_reg.sv
// Lane register that assembles PACK elements into one memory word.
// Tracks the fill slot and per-lane strobes; full flags that an insert this cycle completes the word.
module fw_pack_reg
    import feature_writer_pkg::*;
#(
    parameter int ELEM_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 insert,
    input  logic                                 clear,
    input  logic [ELEM_WIDTH-1:0]                din,
    output logic [PACK-1:0][ELEM_WIDTH-1:0]      lanes,
    output logic [PACK-1:0]                      wstrb,
    output logic [slot_width(PACK)-1:0]          slot,
    output logic                                 full
);

    localparam int SLOT_WIDTH = slot_width(PACK);

    logic [PACK-1:0] slot_oh;

    always_comb begin
        slot_oh       = '0;
        slot_oh[slot] = 1'b1;
    end

    assign full = &(wstrb | slot_oh);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lanes <= '0;
            wstrb <= '0;
            slot  <= '0;
        end else if (clear) begin
            lanes <= '0;
            wstrb <= '0;
            slot  <= '0;
        end else if (insert) begin
            for (int i = 0; i < PACK; i++) begin
                if (slot_oh[i]) begin
                    lanes[i] <= din;
                    wstrb[i] <= 1'b1;
                end
            end
            slot <= slot + SLOT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/feature_writer.sv
// Packs gathered elements into PACK-wide words and writes one output-map tile to feature memory.
// Optional FEATURE_WRITER_RELU_EN: signed elements below zero are clamped to 0 before packing.
module feature_writer
    import feature_writer_pkg::*;
#(
    parameter int ELEM_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_cfg_start,
    input  logic [CNT_WIDTH-1:0]              i_cfg_num_elem,
    input  logic [ADDR_WIDTH-1:0]             i_cfg_base_addr,
    input  logic [ELEM_WIDTH-1:0]             i_gather_data,
    input  logic                              i_gather_valid,
    output logic                              o_feature_writer_finish,
    output logic                              o_mem_wr_en,
    input  logic                              i_mem_ready,
    output logic [ADDR_WIDTH-1:0]             o_mem_addr,
    output logic [word_width(ELEM_WIDTH,PACK)-1:0] o_mem_wdata,
    output logic [PACK-1:0]                   o_mem_wstrb,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_overrun
);

    localparam int SLOT_WIDTH = slot_width(PACK);

    fw_state_e                         state;
    logic [CNT_WIDTH-1:0]              num_q;
    logic [CNT_WIDTH-1:0]              elem_cnt;
    logic [CNT_WIDTH-1:0]              cnt_nxt;
    logic [ADDR_WIDTH-1:0]             addr_q;
    logic [ELEM_WIDTH-1:0]             elem_in;
    logic [PACK-1:0][ELEM_WIDTH-1:0]   lanes;
    logic [SLOT_WIDTH-1:0]             slot;
    logic                              pack_full;
    logic                              pack_insert;
    logic                              pack_clear;
    logic                              wr_hs;

`ifdef FEATURE_WRITER_RELU_EN
    assign elem_in = i_gather_data[ELEM_WIDTH-1] ? '0 : i_gather_data;
`else
    assign elem_in = i_gather_data;
`endif

    assign cnt_nxt     = elem_cnt + CNT_WIDTH'(1);
    assign wr_hs       = (state == WRITE) && i_mem_ready;
    assign pack_insert = (state == COLLECT) && i_gather_valid;
    assign pack_clear  = wr_hs || ((state == IDLE) && i_cfg_start);

    fw_pack_reg #(
        .ELEM_WIDTH (ELEM_WIDTH),
        .PACK       (PACK)
    ) u_pack (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .insert  (pack_insert),
        .clear   (pack_clear),
        .din     (elem_in),
        .lanes   (lanes),
        .wstrb   (o_mem_wstrb),
        .slot    (slot),
        .full    (pack_full)
    );

    assign o_mem_wdata = lanes;
    assign o_mem_addr  = addr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                   <= IDLE;
            num_q                   <= '0;
            elem_cnt                <= '0;
            addr_q                  <= '0;
            o_feature_writer_finish <= 1'b0;
            o_mem_wr_en             <= 1'b0;
            o_busy                  <= 1'b0;
            o_done                  <= 1'b0;
            o_overrun               <= 1'b0;
        end else begin
            o_feature_writer_finish <= 1'b0;
            o_done                  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cfg_start) begin
                        num_q     <= i_cfg_num_elem;
                        addr_q    <= i_cfg_base_addr;
                        elem_cnt  <= '0;
                        o_overrun <= 1'b0;
                        o_busy    <= 1'b1;
                        if (i_cfg_num_elem == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end else if (i_gather_valid) begin
                        o_overrun <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (i_gather_valid) begin
                        elem_cnt <= cnt_nxt;
                        // Word complete or tile exhausted: flush before asking for more.
                        if (pack_full || (cnt_nxt == num_q)) begin
                            state       <= WRITE;
                            o_mem_wr_en <= 1'b1;
                        end else begin
                            o_feature_writer_finish <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (i_gather_valid) begin
                        o_overrun <= 1'b1;
                    end
                    if (i_mem_ready) begin
                        o_mem_wr_en <= 1'b0;
                        addr_q      <= addr_q + ADDR_WIDTH'(1);
                        if (elem_cnt == num_q) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state                   <= COLLECT;
                            o_feature_writer_finish <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (i_gather_valid) begin
                        o_overrun <= 1'b1;
                    end
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_writer.sv
// Randomized and directed bench for feature_writer against a word-level packing model.
// Honors FEATURE_WRITER_RELU_EN the same way as the design build.
module tb_feature_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [15:0] cfg_num;
    logic [11:0] cfg_base;
    logic [7:0]  g_data;
    logic        g_valid;
    logic        fin;
    logic        wr_en;
    logic        mem_ready;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        busy;
    logic        done;
    logic        overrun;

    always #5 clk = ~clk;

    feature_writer dut (
        .i_clk                   (clk),
        .i_rst_n                 (rst_n),
        .i_cfg_start             (cfg_start),
        .i_cfg_num_elem          (cfg_num),
        .i_cfg_base_addr         (cfg_base),
        .i_gather_data           (g_data),
        .i_gather_valid          (g_valid),
        .o_feature_writer_finish (fin),
        .o_mem_wr_en             (wr_en),
        .i_mem_ready             (mem_ready),
        .o_mem_addr              (mem_addr),
        .o_mem_wdata             (mem_wdata),
        .o_mem_wstrb             (mem_wstrb),
        .o_busy                  (busy),
        .o_done                  (done),
        .o_overrun               (overrun)
    );

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    wr_t  wq[$];
    int   fin_cnt = 0, done_cnt = 0, hold_err = 0, last_hs_cyc = 0;
    int   wq_base, fin_base, done_base, hold_base, st_cyc;
    logic [7:0] elems [0:63];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] relu(input logic [7:0] e);
`ifdef FEATURE_WRITER_RELU_EN
        return e[7] ? 8'h00 : e;
`else
        return e;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ($urandom_range(0, 3) != 0);
                default: mem_ready = 1'b0;
            endcase
        end
    end

    // Observes the memory port; main thread only reads these records.
    logic        pv_stall = 1'b0;
    logic [11:0] pv_addr;
    logic [31:0] pv_data;
    logic [3:0]  pv_strb;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_stall = 1'b0;
        end else begin
            if (pv_stall && (!wr_en || mem_addr !== pv_addr || mem_wdata !== pv_data ||
                             mem_wstrb !== pv_strb))
                hold_err++;
            if (wr_en && mem_ready) begin
                wq.push_back('{a: mem_addr, d: mem_wdata, s: mem_wstrb});
                last_hs_cyc = cyc;
            end
            if (fin)  fin_cnt++;
            if (done) done_cnt++;
            pv_stall = wr_en && !mem_ready;
            pv_addr  = mem_addr;
            pv_data  = mem_wdata;
            pv_strb  = mem_wstrb;
        end
    end

    task automatic start_tile(input logic [11:0] base, input int num);
        wq_base   = wq.size();
        fin_base  = fin_cnt;
        done_base = done_cnt;
        hold_base = hold_err;
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_num   = 16'(num);
        cfg_base  = base;
        st_cyc    = cyc;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk("start_ovr_clr", overrun, 0);
        chk("start_busy", busy, 1);
    endtask

    task automatic wait_finish(output int fcyc);
        int n = 0;
        fcyc = -1;
        while (n < 300) begin
            @(negedge clk);
            if (fin) begin
                fcyc = cyc;
                break;
            end
            n++;
        end
        if (fcyc < 0) chk("finish_timeout", 0, 1);
    endtask

    task automatic drive_elem(input logic [7:0] d);
        @(posedge clk); #1;
        g_valid = 1'b1;
        g_data  = d;
        @(posedge clk); #1;
        g_valid = 1'b0;
    endtask

    task automatic feed(input int lo, input int hi, input bit wait_first);
        int fc;
        for (int i = lo; i < hi; i++) begin
            if (i > lo || wait_first) wait_finish(fc);
            drive_elem(elems[i]);
        end
    endtask

    task automatic finish_tile(input logic [11:0] base, input int num);
        int  n = 0;
        int  dcyc = -1;
        int  nw;
        wr_t w;
        logic [31:0] ed;
        logic [3:0]  es;
        while (n < 600) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
            n++;
        end
        if (dcyc < 0) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("busy_after", busy, 0);
        @(negedge clk);
        if (num == 0) chk("zero_lat", (dcyc - st_cyc >= 1) && (dcyc - st_cyc <= 2), 1);
        else          chk("done_lat", dcyc - last_hs_cyc, 1);
        nw = (num + 3) / 4;
        chk("n_writes", wq.size() - wq_base, nw);
        for (int k = 0; k < nw && (wq_base + k) < wq.size(); k++) begin
            ed = '0;
            es = '0;
            for (int j = 0; j < 4; j++) begin
                if (k * 4 + j < num) begin
                    ed[j*8 +: 8] = relu(elems[k*4 + j]);
                    es[j]        = 1'b1;
                end
            end
            w = wq[wq_base + k];
            chk("wr_addr", w.a, 12'(base + 12'(k)));
            chk("wr_data", w.d, ed);
            chk("wr_strb", w.s, es);
        end
        chk("n_finish", fin_cnt - fin_base, (num > 0) ? num - 1 : 0);
        chk("n_done", done_cnt - done_base, 1);
        chk("wr_hold", hold_err - hold_base, 0);
    endtask

    task automatic run_tile(input logic [11:0] base, input int num);
        start_tile(base, num);
        feed(0, num, 1'b0);
        finish_tile(base, num);
    endtask

    initial begin
        int fc, f0, nn;
        logic [31:0] exp_relu;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_num = '0; cfg_base = '0;
        g_data = '0; g_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {busy, wr_en, fin, done, overrun, mem_addr, mem_wdata, mem_wstrb}, 0);
        rst_n = 1'b1;

        // single full word
        elems[0] = 8'h11; elems[1] = 8'h22; elems[2] = 8'h33; elems[3] = 8'h44;
        run_tile(12'h010, 4);
`ifndef FEATURE_WRITER_RELU_EN
        chk("full_word", wq[wq.size()-1].d, 32'h44332211);
`endif

        // partial tail
        for (int i = 0; i < 6; i++) elems[i] = 8'(i + 1);
        run_tile(12'h020, 6);
        chk("tail_word", wq[wq.size()-1].d, 32'h00000605);
        chk("tail_strb", wq[wq.size()-1].s, 4'b0011);

        // backpressure on the first word of an 8-element tile
        for (int i = 0; i < 8; i++) elems[i] = 8'($urandom_range(0, 127));
        ready_mode = 2;
        start_tile(12'h200, 8);
        feed(0, 4, 1'b0);
        nn = 0;
        while (!wr_en && nn < 50) begin @(negedge clk); nn++; end
        f0 = fin_cnt;
        repeat (5) @(negedge clk);
        chk("bp_wr_en", wr_en, 1);
        chk("bp_nofin", fin_cnt - f0, 0);
        ready_mode = 0;
        wait_finish(fc);
        chk("bp_fin_lat", fc - last_hs_cyc, 1);
        drive_elem(elems[4]);
        feed(5, 8, 1'b1);
        finish_tile(12'h200, 8);

        // zero length and address wrap
        start_tile(12'h055, 0);
        finish_tile(12'h055, 0);
        for (int i = 0; i < 8; i++) elems[i] = 8'($urandom_range(0, 127));
        run_tile(12'hFFF, 8);
        chk("wrap_addr", wq[wq.size()-1].a, 12'h000);

        // overrun: element strobed while a write is pending is dropped
        elems[0] = 8'h11; elems[1] = 8'h22; elems[2] = 8'h33; elems[3] = 8'h44;
        ready_mode = 2;
        start_tile(12'h100, 4);
        feed(0, 4, 1'b0);
        drive_elem(8'h99);
        @(negedge clk);
        chk("ovr_set", overrun, 1);
        chk("ovr_wr_en", wr_en, 1);
        ready_mode = 0;
        finish_tile(12'h100, 4);
        chk("ovr_sticky", overrun, 1);

        // reset in the middle of COLLECT
        start_tile(12'h300, 4);
        feed(0, 2, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {busy, wr_en, fin, done, overrun, mem_addr, mem_wdata, mem_wstrb}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) elems[i] = 8'(8'hA0 + i);
        run_tile(12'h300, 4);

        // ReLU pattern
        elems[0] = 8'h80; elems[1] = 8'h7F; elems[2] = 8'hFF; elems[3] = 8'h01;
        run_tile(12'h400, 4);
`ifdef FEATURE_WRITER_RELU_EN
        exp_relu = 32'h01007F00;
`else
        exp_relu = 32'h01FF7F80;
`endif
        chk("relu_word", wq[wq.size()-1].d, exp_relu);

        // randomized tiles with random backpressure
        for (int t = 0; t < 12; t++) begin
            nn = $urandom_range(1, 20);
            for (int i = 0; i < nn; i++) elems[i] = 8'($urandom);
            ready_mode = $urandom_range(0, 1);
            run_tile(12'($urandom), nn);
        end
        ready_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/feature_writer.md
Name: feature_writer

Overview:
- Downstream neighbour of the kernel gather stage.
- Consumes the gathered per-channel accumulated elements, one element per valid strobe. Packs PACK elements into one memory word and writes the words to feature memory at consecutive addresses.
- Returns a one-cycle `o_feature_writer_finish` pulse whenever it can accept the next element. The gather stage uses this pulse to advance its SRAM read address.
- One output-map tile is written per `i_cfg_start` command.

Parameters:
- ELEM_WIDTH, 8, width of one gathered element (gather DATA_WIDTH/4).
- PACK, 4, elements per memory word; power of two, ≥2.
- ADDR_WIDTH, 12, feature-memory word-address width.
- CNT_WIDTH, 16, element-count width.

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cfg_start  in  1  one-cycle pulse that launches a tile; sampled only in IDLE.
- i_cfg_num_elem  in  CNT_WIDTH  number of elements in the tile; latched on start.
- i_cfg_base_addr  in  ADDR_WIDTH  first word address; latched on start.
- i_gather_data  in  ELEM_WIDTH  gathered element.
- i_gather_valid  in  1  element strobe, one cycle per element.
- o_feature_writer_finish  out  1  one-cycle pulse meaning "send next element".
- o_mem_wr_en  out  1  write request; held until accepted.
- i_mem_ready  in  1  memory accepts the write when high together with o_mem_wr_en.
- o_mem_addr  out  ADDR_WIDTH  word address.
- o_mem_wdata  out  ELEM_WIDTH*PACK  packed word; element 0 in LSBs.
- o_mem_wstrb  out  PACK  per-element byte-lane enables.
- o_busy  out  1  high from start until DONE is left.
- o_done  out  1  one-cycle pulse when the tile is complete.
- o_overrun  out  1  sticky error flag; cleared only by reset or the next accepted start.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters, pack register and latched configuration cleared. Reset mid-write abandons the word with no partial write.
- States and transitions:
  - IDLE: on i_cfg_start, latch the configuration, clear o_overrun, set o_busy, go to COLLECT. If num_elem==0, go to DONE instead.
  - COLLECT: on i_gather_valid, store the element in lane `slot`, set wstrb[slot], slot++, elem_cnt++.
    - If slot wraps to 0, or elem_cnt reaches num_elem, go to WRITE.
    - Otherwise pulse o_feature_writer_finish on the next cycle (1-cycle latency from valid).
  - WRITE: assert o_mem_wr_en with stable addr/wdata/wstrb until i_mem_ready.
    - On the handshake cycle: addr++ (wraps mod 2^ADDR_WIDTH), clear the pack register and wstrb.
    - If elem_cnt==num_elem, go to DONE. Otherwise go to COLLECT and pulse finish on the next cycle.
  - DONE: pulse o_done for one cycle, deassert o_busy, return to IDLE.
  - A final partial word is written with only its filled wstrb bits set; unused lanes are zero.
- Finish pulses: no finish pulse is issued after the final element. Total finish pulses per tile = num_elem−1.
- Overrun: i_gather_valid in WRITE, DONE or IDLE sets o_overrun and discards the element; counters are unchanged.
- i_cfg_start outside IDLE is ignored.
- i_mem_ready outside WRITE is ignored.
- Elements are consumed in arrival order, with no reordering.
- Throughput: one element per 2 cycles in COLLECT (valid → finish → valid). A word write adds at least 1 cycle.

Optional Feature:
- FEATURE_WRITER_RELU_EN defined: each element is treated as signed two's complement; negative values are replaced by 0 before packing. This adds no extra latency.
- Not defined: elements are packed unmodified.

Decomposition:
- Package feature_writer_pkg holds:
  - the FSM state enum (IDLE, COLLECT, WRITE, DONE);
  - the SLOT_WIDTH=$clog2(PACK) localparam helper;
  - the word-width function ELEM_WIDTH*PACK.
- One natural sub-module, fw_pack_reg: the lane register plus wstrb and slot counter, with insert and clear controls and a full flag.

Test Plan:
- Single full word:
  - Stimulus: base=0x010, num=4, elements 0x11,0x22,0x33,0x44, each sent after the finish pulse; i_mem_ready=1.
  - Required: one write at addr 0x010, wdata=0x44332211, wstrb=1111; 3 finish pulses; o_done 1 cycle after the handshake.
- Partial tail:
  - Stimulus: num=6, elements 1..6.
  - Required: writes at base (0x04030201, wstrb=1111) and base+1 (0x00000605, wstrb=0011); 5 finish pulses.
- Backpressure:
  - Stimulus: i_mem_ready low for 5 cycles during WRITE.
  - Required: wr_en, addr and wdata stay stable; no finish pulse until 1 cycle after ready rises.
- Zero length / address wrap:
  - Zero length: num=0 → o_done 2 cycles after start, no writes.
  - Wrap: base=0xFFF, num=8 → writes at 0xFFF then 0x000.
- Overrun and reset:
  - Valid pulsed in WRITE → o_overrun=1 and the element is dropped.
  - Reset asserted mid-COLLECT → all outputs 0 immediately; a new start works normally.
- ReLU (with FEATURE_WRITER_RELU_EN):
  - Stimulus: elements 0x80, 0x7F, 0xFF, 0x01.
  - Required: wdata=0x01007F00.
